// File: rtl/tree_vc_destport_holder_pkg.sv
// Shared constants, per-VC queue state and width helpers for the destport holder.
// MAX_PCK (entries per VC, power of two, >= 2) is fixed here for the whole slice.
package tree_vc_destport_holder_pkg;

   localparam int MAX_PCK = 2;
   localparam int PCKW    = (MAX_PCK > 1) ? $clog2(MAX_PCK) : 1;
   localparam int CNTW    = PCKW + 1;

   typedef struct packed {
      logic [CNTW-1:0] count;
      logic [PCKW-1:0] rd_ptr;
      logic [PCKW-1:0] wr_ptr;
   } vc_state_t;

   // Encoded destport width for K down ports plus one up port.
   function automatic int dspw(input int k);
      return (k + 1 > 1) ? $clog2(k + 1) : 1;
   endfunction

   // Width of the decoded request once the own port is (optionally) removed.
   function automatic int p1(input int k, input int self_loop_en);
      return (self_loop_en != 0) ? k + 1 : k;
   endfunction

endpackage

// File: rtl/tree_vc_destport_holder_if.sv
// Flit write/pop observation bus and per-VC destport request outputs.
interface tree_vc_destport_holder_if #(
   parameter int V    = 2,
   parameter int DSPW = 2,
   parameter int P_1  = 2
);
   // There is no ready: writes and pops report what the input buffer already
   // did this cycle. An event counts when its wr/pop qualifier is high and its
   // one-hot VC selects a channel; it is always consumed in that same cycle.
   logic            flit_in_wr;
   logic            flit_in_hdr;
   logic            flit_in_tail;
   logic [V-1:0]    flit_in_vc;
   logic [DSPW-1:0] destport_in;
   logic            flit_out_pop;
   logic            flit_out_tail;
   logic [V-1:0]    flit_out_vc;

   logic [V-1:0]      dest_valid;
   logic [V*P_1-1:0]  dest_port_out;
   logic [V*DSPW-1:0] dest_port_enc;
   logic              ovf_err;
   logic              udf_err;
   logic              route_err;

   modport master (
      output flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_vc, destport_in,
      output flit_out_pop, flit_out_tail, flit_out_vc,
      input  dest_valid, dest_port_out, dest_port_enc, ovf_err, udf_err, route_err
   );

   modport slave (
      input  flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_vc, destport_in,
      input  flit_out_pop, flit_out_tail, flit_out_vc,
      output dest_valid, dest_port_out, dest_port_enc, ovf_err, udf_err, route_err
   );

endinterface

// File: rtl/tree_destp_fifo.sv
// Single-VC circular queue of encoded destports, one entry per pending packet.
// Emits single-cycle overflow/underflow pulses and a push-accepted strobe.
module tree_destp_fifo
   import tree_vc_destport_holder_pkg::*;
#(
   parameter int DSPW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [DSPW-1:0] din_i,
   output logic            valid_o,
   output logic [DSPW-1:0] head_o,
   output logic            accept_o,
   output logic            ovf_o,
   output logic            udf_o
);

   vc_state_t       state_q, state_d;
   logic [DSPW-1:0] mem_q [MAX_PCK];
   logic            empty;
   logic            full;
   logic            pop_ok;

   assign empty    = (state_q.count == '0);
   assign full     = (state_q.count == CNTW'(MAX_PCK));
   assign pop_ok   = pop_i & ~empty;
   // A pop in the same cycle frees the slot a push into a full queue needs.
   assign accept_o = push_i & (~full | pop_ok);
   assign ovf_o    = push_i & full & ~pop_i;
   assign udf_o    = pop_i & empty;

   assign valid_o  = ~empty;
   assign head_o   = mem_q[state_q.rd_ptr];

   always_comb begin
      state_d = state_q;
      if (accept_o) state_d.wr_ptr = state_q.wr_ptr + 1'b1;
      if (pop_ok)   state_d.rd_ptr = state_q.rd_ptr + 1'b1;
      case ({accept_o, pop_ok})
         2'b10:   state_d.count = state_q.count + 1'b1;
         2'b01:   state_d.count = state_q.count - 1'b1;
         default: state_d.count = state_q.count;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         for (int i = 0; i < MAX_PCK; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept_o) mem_q[state_q.wr_ptr] <= din_i;
      end
   end

endmodule

// File: rtl/tree_vc_destport_holder.sv
// Per-input-port destport holder: one queue per VC, decoded self-masked requests.
// Optional illegal-destport checking is enabled by defining TREE_DSTP_CHECK_EN.
module tree_vc_destport_holder
   import tree_vc_destport_holder_pkg::*;
#(
   parameter int K            = 2,
   parameter int L            = 2,
   parameter int V            = 2,
   parameter int SW_LOC       = 0,
   parameter int SELF_LOOP_EN = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   tree_vc_destport_holder_if.slave  bus
);

   localparam int P    = K + 1;
   localparam int DSPW = dspw(K);
   localparam int P_1  = p1(K, SELF_LOOP_EN);

   if (L < 1 || K < 1 || V < 1 || SW_LOC > K || MAX_PCK < 2 ||
       (MAX_PCK & (MAX_PCK - 1)) != 0) begin : g_bad_cfg
      $error("tree_vc_destport_holder: unsupported parameter set");
   end

   logic [V-1:0] ovf_v;
   logic [V-1:0] udf_v;
   logic         ovf_q, ovf_d;
   logic         udf_q, udf_d;
`ifdef TREE_DSTP_CHECK_EN
   logic [V-1:0] rte_v;
   logic         rte_q, rte_d;
`endif

   for (genvar v = 0; v < V; v++) begin : g_vc
      logic            push;
      logic            pop;
      logic            valid;
      logic [DSPW-1:0] head;
      logic [P-1:0]    onehot;
      logic [P_1-1:0]  masked;

      assign push = bus.flit_in_wr & bus.flit_in_hdr & bus.flit_in_vc[v];
      assign pop  = bus.flit_out_pop & bus.flit_out_tail & bus.flit_out_vc[v];

`ifdef TREE_DSTP_CHECK_EN
      logic accept;
      tree_destp_fifo #(.DSPW(DSPW)) u_fifo (
         .clk(clk), .reset(reset), .push_i(push), .pop_i(pop),
         .din_i(bus.destport_in), .valid_o(valid), .head_o(head),
         .accept_o(accept), .ovf_o(ovf_v[v]), .udf_o(udf_v[v])
      );
      assign rte_v[v] = accept &
                        ((32'(bus.destport_in) > 32'(K)) |
                         ((SELF_LOOP_EN == 0) & (32'(bus.destport_in) == 32'(SW_LOC))));
`else
      tree_destp_fifo #(.DSPW(DSPW)) u_fifo (
         .clk(clk), .reset(reset), .push_i(push), .pop_i(pop),
         .din_i(bus.destport_in), .valid_o(valid), .head_o(head),
         .accept_o(), .ovf_o(ovf_v[v]), .udf_o(udf_v[v])
      );
`endif

      // Values above K match no bit, so an illegal entry decodes to all-zero.
      always_comb begin
         onehot = '0;
         for (int i = 0; i < P; i++) onehot[i] = (head == DSPW'(i));
      end

      if (SELF_LOOP_EN != 0) begin : g_keep_self
         assign masked = onehot;
      end else begin : g_drop_self
         always_comb begin
            masked = '0;
            for (int j = 0; j < P_1; j++) masked[j] = (j < SW_LOC) ? onehot[j] : onehot[j+1];
         end
      end

      assign bus.dest_valid[v]                    = valid;
      assign bus.dest_port_enc[v*DSPW +: DSPW]    = head;
      assign bus.dest_port_out[v*P_1 +: P_1]      = valid ? masked : '0;
   end

   always_comb begin
      ovf_d = ovf_q | (|ovf_v);
      udf_d = udf_q | (|udf_v);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.ovf_err = ovf_q;
   assign bus.udf_err = udf_q;

`ifdef TREE_DSTP_CHECK_EN
   always_comb rte_d = rte_q | (|rte_v);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rte_q <= 1'b0;
      else       rte_q <= rte_d;
   end

   assign bus.route_err = rte_q;
`else
   assign bus.route_err = 1'b0;
`endif

endmodule
